// File: rtl/program_sequencer_pkg.sv
// Shared types and constants for the program sequencer: FSM states, ALU codes
// with special sequencing, the HALT word and instruction-register field positions.
package program_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_OPERAND,
        ST_EXEC,
        ST_WAIT_ALU,
        ST_WRITE,
        ST_HALT,
        ST_ERROR
    } seq_state_t;

    localparam logic [2:0] ALU_MUL  = 3'b010;
    localparam logic [2:0] ALU_DIV  = 3'b011;
    localparam logic [2:0] ALU_IMM0 = 3'b110;
    localparam logic [2:0] ALU_IMM1 = 3'b111;

    localparam logic [15:0] HALT_WORD = 16'h0000;

    localparam int unsigned IR_A_LSB   = 12;
    localparam int unsigned IR_B_LSB   = 8;
    localparam int unsigned IR_ALU_LSB = 5;
    localparam int unsigned IR_W_LSB   = 1;
    localparam int unsigned IR_WE_BIT  = 0;

    typedef struct packed {
        logic [3:0] a_addr;
        logic [3:0] b_addr;
        logic [2:0] alu;
        logic [3:0] w_addr;
        logic       we;
    } ir_fields_t;

    function automatic logic is_muldiv_code(input logic [2:0] code);
        return (code == ALU_MUL) || (code == ALU_DIV);
    endfunction

endpackage

// File: rtl/program_sequencer_decode.sv
// Combinational instruction decode: splits the instruction register into
// register-file fields and flags multi-cycle ALU ops and the HALT word.
module instr_decode
    import program_sequencer_pkg::*;
(
    input  logic [15:0] ir,
    input  logic [15:0] fetched,
    output ir_fields_t  fields,
    output logic        is_muldiv,
    output logic        is_halt
);

    always_comb begin
        fields.a_addr = ir[IR_A_LSB +: 4];
        fields.b_addr = ir[IR_B_LSB +: 4];
        fields.alu    = ir[IR_ALU_LSB +: 3];
        fields.w_addr = ir[IR_W_LSB +: 4];
        fields.we     = ir[IR_WE_BIT];
    end

    assign is_muldiv = is_muldiv_code(ir[IR_ALU_LSB +: 3]);
    // The HALT test looks at the ROM word itself, before it lands in IR.
    assign is_halt   = (fetched == HALT_WORD);

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: fetches instructions from a synchronous ROM and drives the
// register-file controls, sequencing multiply/divide through the ALU handshake.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int unsigned PC_W        = 4,
    parameter int unsigned PROG_LEN    = 15,
    parameter int unsigned ALU_TIMEOUT = 32
) (
    input  logic            CLK_In,
    input  logic            RST_In,
    input  logic            Run,
    input  logic [15:0]     Instr_rdata,
    input  logic            Alu_done,
    output logic [PC_W-1:0] Instr_addr,
    output logic [3:0]      Aaddr,
    output logic [3:0]      Baddr,
    output logic [2:0]      Instruction_alu,
    output logic [3:0]      Write_addr,
    output logic            Write_Enable,
    output logic [3:0]      State,
    output logic            Alu_start,
    output logic            Halted,
    output logic            Error,
    output logic            Busy
);

    localparam int unsigned CNT_W = $clog2(ALU_TIMEOUT + 1);

    seq_state_t       state, state_next;
    logic [PC_W-1:0]  pc, pc_next;
    logic [15:0]      ir, ir_next;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
    logic             armed, armed_next;

    ir_fields_t fields;
    logic       is_muldiv;
    logic       is_halt;
    logic       last_step;
    logic       in_program;

    instr_decode u_decode (
        .ir        (ir),
        .fetched   (Instr_rdata),
        .fields    (fields),
        .is_muldiv (is_muldiv),
        .is_halt   (is_halt)
    );

    always_ff @(posedge CLK_In) begin
        if (RST_In) begin
            state    <= ST_IDLE;
            pc       <= '0;
            ir       <= '0;
            wait_cnt <= '0;
            armed    <= 1'b0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            ir       <= ir_next;
            wait_cnt <= wait_cnt_next;
            armed    <= armed_next;
        end
    end

    assign last_step = ((32'(pc) + 32'd1) == PROG_LEN);

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        ir_next         = ir;
        wait_cnt_next   = wait_cnt;
        armed_next      = 1'b0;
        Instruction_alu = '0;
        Write_Enable    = 1'b0;
        Alu_start       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Run) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                ir_next    = Instr_rdata;
                state_next = is_halt ? ST_HALT : ST_OPERAND;
            end
            // Mul/div codes would make the register file write RAM[14]/[15] on
            // every edge, so they are hidden until the WRITE cycle.
            ST_OPERAND: begin
                Instruction_alu = is_muldiv ? '0 : fields.alu;
                state_next      = ST_EXEC;
            end
            ST_EXEC: begin
                Instruction_alu = is_muldiv ? '0 : fields.alu;
                if (is_muldiv) begin
                    Alu_start     = 1'b1;
                    wait_cnt_next = '0;
                    state_next    = ST_WAIT_ALU;
                end else begin
                    state_next = ST_WRITE;
                end
            end
            ST_WAIT_ALU: begin
                Instruction_alu = is_muldiv ? '0 : fields.alu;
                if (Alu_done) begin
                    state_next = ST_WRITE;
                end else if (wait_cnt == CNT_W'(ALU_TIMEOUT - 1)) begin
                    state_next = ST_ERROR;
                end else begin
                    wait_cnt_next = wait_cnt + CNT_W'(1);
                end
            end
            ST_WRITE: begin
                Instruction_alu = fields.alu;
                Write_Enable    = fields.we;
                if (last_step) begin
                    state_next = ST_HALT;
                end else begin
                    pc_next    = pc + PC_W'(1);
                    state_next = Run ? ST_FETCH : ST_IDLE;
                end
            end
            // Restart needs a Run low-then-high; armed remembers the low phase.
            ST_HALT: begin
                armed_next = armed | ~Run;
                if (Run && armed) begin
                    armed_next = 1'b0;
                    pc_next    = '0;
                    state_next = ST_FETCH;
                end
            end
            ST_ERROR: begin
                state_next = ST_ERROR;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign in_program = state inside {ST_FETCH, ST_DECODE, ST_OPERAND,
                                      ST_EXEC, ST_WAIT_ALU, ST_WRITE};

    assign Instr_addr = pc;
    assign Aaddr      = fields.a_addr;
    assign Baddr      = fields.b_addr;
    assign Write_addr = fields.w_addr;
    assign State      = in_program ? (4'(pc) + 4'd1) : 4'd0;
    assign Busy       = in_program;
    assign Halted     = (state == ST_HALT);
    assign Error      = (state == ST_ERROR);

endmodule
